// File: rtl/stream_test_pkg.sv
// Shared definitions for the stream traffic generator/checker.
//   mode_e      : pattern selector (INC, LFSR, FIXED)
//   LFSR_SEED   : start state of both the TX and the RX LFSR
//   lfsr_next   : one step of the 32-bit Fibonacci LFSR
//   replicate32 : 32-bit word tiled across MAX_W bits; callers truncate
package stream_test_pkg;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_FIXED = 2'd2
    } mode_e;

    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

    // Widest stream word that replicate32 can fill (TX/RX data up to 512 bits).
    localparam int MAX_W = 512;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Low bits come first, so truncating the result keeps the low part of the state.
    function automatic logic [MAX_W-1:0] replicate32(input logic [31:0] s);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W / 32; i++) begin
            r[i*32 +: 32] = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_cnt32.sv
// 32-bit counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : synchronous return to zero, wins over inc
//   inc        : count one event
//   count      : current value
module sat_cnt32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != 32'hFFFF_FFFF)) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/stream_traffic_gen_chk.sv
// Traffic generator and checker for the FIFO stream ports.
//   clk, rstn_async         : clock; async active-low reset, released through a 2-flop synchroniser
//   mode, tx_en, clear      : pattern select (3 acts as INC), generator enable, synchronous clear
//   tx_valid/tx_ready/tx_data : generated TX stream
//   rx_valid/rx_ready/rx_data : checked RX stream (rx_ready is 1 whenever out of reset)
//   tx_count, rx_count, err_count : saturating beat and mismatch counters
//   first_err_exp/got, err_seen   : capture of the first mismatch since reset/clear
//   err_led                 : held high for LED_HOLD cycles after the latest mismatch
module stream_traffic_gen_chk
    import stream_test_pkg::*;
#(
    parameter int         TX_DEXP   = 3,
    parameter int         RX_DEXP   = 0,
    parameter int         LED_HOLD  = 50000000,
    parameter logic [7:0] FIXED_PAT = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rstn_async,
    input  logic [1:0]                mode,
    input  logic                      tx_en,
    input  logic                      clear,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [(8<<TX_DEXP)-1:0]   tx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    input  logic [(8<<RX_DEXP)-1:0]   rx_data,
    output logic [31:0]               tx_count,
    output logic [31:0]               rx_count,
    output logic [31:0]               err_count,
    output logic [(8<<RX_DEXP)-1:0]   first_err_exp,
    output logic [(8<<RX_DEXP)-1:0]   first_err_got,
    output logic                      err_seen,
    output logic                      err_led
);

    localparam int          TW        = 8 << TX_DEXP;
    localparam int          RW        = 8 << RX_DEXP;
    localparam logic [31:0] HOLD_LOAD = 32'(LED_HOLD - 1);

    // Reset asserts at once, releases two edges later; rstn resets all other state.
    logic [1:0] rst_sync_reg;
    logic       rstn;

    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rstn     = rst_sync_reg[1];
    assign rx_ready = rstn;

    mode_e cur_mode;

    always_comb begin
        case (mode)
            2'd1:    cur_mode = MODE_LFSR;
            2'd2:    cur_mode = MODE_FIXED;
            default: cur_mode = MODE_INC;
        endcase
    end

    // ---------------- generator ----------------
    logic [TW-1:0] inc_cnt_reg;
    logic [31:0]   tx_lfsr_reg;
    logic [TW-1:0] tx_word;
    logic          tx_fire;

    assign tx_valid = tx_en & ~clear & rstn;
    assign tx_fire  = tx_valid & tx_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inc_cnt_reg <= '0;
            tx_lfsr_reg <= LFSR_SEED;
        end else if (clear) begin
            inc_cnt_reg <= '0;
            tx_lfsr_reg <= LFSR_SEED;
        end else if (tx_fire) begin
            inc_cnt_reg <= inc_cnt_reg + TW'(1);
            tx_lfsr_reg <= lfsr_next(tx_lfsr_reg);
        end
    end

    // Data depends only on state and mode, so it holds steady through a stall.
    always_comb begin
        case (cur_mode)
            MODE_LFSR:  tx_word = TW'(replicate32(tx_lfsr_reg));
            MODE_FIXED: tx_word = TW'(replicate32({4{FIXED_PAT}}));
            default:    tx_word = inc_cnt_reg;
        endcase
    end

    assign tx_data = rstn ? tx_word : '0;

    // ---------------- checker ----------------
    logic          rx_fire;
    logic          rx_mismatch;
    logic          rx_err;
    logic [RW-1:0] rx_exp;
    logic [RW-1:0] prev_reg;
    logic          locked_reg;
    logic [31:0]   rx_lfsr_reg;
    logic [31:0]   hold_reg;
    logic          err_seen_reg;
    logic          err_led_reg;
    logic [RW-1:0] first_exp_reg;
    logic [RW-1:0] first_got_reg;

    assign rx_fire = rx_valid & rx_ready & ~clear;

    always_comb begin
        rx_exp      = prev_reg + RW'(1);
        rx_mismatch = 1'b0;
        case (cur_mode)
            MODE_LFSR: begin
                rx_exp      = RW'(replicate32(rx_lfsr_reg));
                rx_mismatch = (rx_data != rx_exp);
            end
            MODE_FIXED: begin
                rx_exp      = RW'(replicate32({4{FIXED_PAT}}));
                rx_mismatch = (rx_data != rx_exp);
            end
            default: begin
                // INC locks onto whatever arrives first and only compares afterwards.
                rx_mismatch = locked_reg && (rx_data != rx_exp);
            end
        endcase
    end

    assign rx_err = rx_fire & rx_mismatch;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || clear) begin
            prev_reg      <= '0;
            locked_reg    <= 1'b0;
            rx_lfsr_reg   <= LFSR_SEED;
            hold_reg      <= '0;
            err_seen_reg  <= 1'b0;
            err_led_reg   <= 1'b0;
            first_exp_reg <= '0;
            first_got_reg <= '0;
        end else begin
            if (rx_fire) begin
                // Reloading from the received beat makes an INC error cost one count, then resync.
                prev_reg    <= rx_data;
                locked_reg  <= 1'b1;
                rx_lfsr_reg <= lfsr_next(rx_lfsr_reg);
            end
            if (rx_err) begin
                hold_reg    <= HOLD_LOAD;
                err_led_reg <= 1'b1;
                if (!err_seen_reg) begin
                    err_seen_reg  <= 1'b1;
                    first_exp_reg <= rx_exp;
                    first_got_reg <= rx_data;
                end
            end else begin
                // LED stays lit through the cycle in which the hold counter reaches 0.
                err_led_reg <= (hold_reg != 32'd0);
                if (hold_reg != 32'd0) begin
                    hold_reg <= hold_reg - 32'd1;
                end
            end
        end
    end

    assign err_seen      = err_seen_reg;
    assign err_led       = err_led_reg;
    assign first_err_exp = first_exp_reg;
    assign first_err_got = first_got_reg;

    sat_cnt32 u_tx_cnt (
        .clk   (clk),
        .rst_n (rstn),
        .clear (clear),
        .inc   (tx_fire),
        .count (tx_count)
    );

    sat_cnt32 u_rx_cnt (
        .clk   (clk),
        .rst_n (rstn),
        .clear (clear),
        .inc   (rx_fire),
        .count (rx_count)
    );

    sat_cnt32 u_err_cnt (
        .clk   (clk),
        .rst_n (rstn),
        .clear (clear),
        .inc   (rx_err),
        .count (err_count)
    );

endmodule

// File: tb/tb_stream_traffic_gen_chk.sv
// Self-checking bench for stream_traffic_gen_chk (TW=64, RW=8, LED_HOLD=10).
// The RX port is either driven directly or looped back from the low byte of TX.
module tb_stream_traffic_gen_chk;

    localparam int LED_HOLD = 10;

    logic        clk = 1'b0;
    logic        rstn_async;
    logic [1:0]  mode;
    logic        tx_en;
    logic        clear;
    logic        tx_valid;
    logic        tx_ready;
    logic [63:0] tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic [31:0] tx_count;
    logic [31:0] rx_count;
    logic [31:0] err_count;
    logic [7:0]  first_err_exp;
    logic [7:0]  first_err_got;
    logic        err_seen;
    logic        err_led;

    logic        loop_en;
    logic        rx_valid_drv;
    logic [7:0]  rx_data_drv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rx_valid = loop_en ? (tx_valid & tx_ready) : rx_valid_drv;
    assign rx_data  = loop_en ? tx_data[7:0] : rx_data_drv;

    stream_traffic_gen_chk #(
        .TX_DEXP   (3),
        .RX_DEXP   (0),
        .LED_HOLD  (LED_HOLD),
        .FIXED_PAT (8'hA5)
    ) dut (
        .clk           (clk),
        .rstn_async    (rstn_async),
        .mode          (mode),
        .tx_en         (tx_en),
        .clear         (clear),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .err_count     (err_count),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got),
        .err_seen      (err_seen),
        .err_led       (err_led)
    );

    // ---------------- reference model (beat level) ----------------
    logic [63:0] m_cnt;
    logic [31:0] m_lfsr;
    logic [31:0] m_rx_lfsr;
    logic [31:0] m_txc;
    logic [31:0] m_rxc;
    logic [31:0] m_errc;
    logic        m_locked;
    logic [7:0]  m_prev;
    logic [7:0]  m_fexp;
    logic [7:0]  m_fgot;
    logic        m_seen;
    int          m_led_left;

    function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return (s << 1) | {31'd0, fb};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [63:0] ref_tx_word();
        case (mode)
            2'd1:    return {m_lfsr, m_lfsr};
            2'd2:    return {8{8'hA5}};
            default: return m_cnt;
        endcase
    endfunction

    function automatic logic [7:0] ref_rx_exp();
        case (mode)
            2'd1:    return m_rx_lfsr[7:0];
            2'd2:    return 8'hA5;
            default: return m_prev + 8'd1;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt      = '0;
        m_lfsr     = 32'h1;
        m_rx_lfsr  = 32'h1;
        m_txc      = '0;
        m_rxc      = '0;
        m_errc     = '0;
        m_locked   = 1'b0;
        m_prev     = '0;
        m_fexp     = '0;
        m_fgot     = '0;
        m_seen     = 1'b0;
        m_led_left = 0;
    endtask

    // Advance the model by the beats the current inputs imply, then one clock.
    task automatic tick();
        logic        txf;
        logic        rxf;
        logic        bad;
        logic [63:0] w;
        logic [7:0]  rd;
        logic [7:0]  ex;
        w   = ref_tx_word();
        ex  = ref_rx_exp();
        txf = tx_en && !clear && tx_ready;
        rxf = !clear && (loop_en ? txf : rx_valid_drv);
        rd  = loop_en ? w[7:0] : rx_data_drv;
        if (clear) begin
            model_reset();
        end else begin
            bad = 1'b0;
            if (rxf) begin
                if (mode == 2'd1 || mode == 2'd2) bad = (rd != ex);
                else                              bad = m_locked && (rd != ex);
                m_prev    = rd;
                m_locked  = 1'b1;
                m_rx_lfsr = ref_lfsr(m_rx_lfsr);
                m_rxc     = sat_inc(m_rxc);
            end
            if (bad) begin
                m_errc     = sat_inc(m_errc);
                m_led_left = LED_HOLD;
                if (!m_seen) begin
                    m_seen = 1'b1;
                    m_fexp = ex;
                    m_fgot = rd;
                end
            end else if (m_led_left > 0) begin
                m_led_left = m_led_left - 1;
            end
            if (txf) begin
                m_cnt  = m_cnt + 64'd1;
                m_lfsr = ref_lfsr(m_lfsr);
                m_txc  = sat_inc(m_txc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        tick();
        clear = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn_async = 1'b1;
        #2;
        rstn_async = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tx_en = 1'b1;
        tx_ready = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        checks++; if (tx_data !== 64'd0) begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
        checks++; if ({tx_count, rx_count, err_count} !== 96'd0) begin errors++; $display("FAIL reset_counts: got %h/%h/%h want 0", tx_count, rx_count, err_count); end
        checks++; if ({err_seen, err_led, first_err_exp, first_err_got} !== 18'd0) begin errors++; $display("FAIL reset_err: got %b %b %h %h want 0", err_seen, err_led, first_err_exp, first_err_got); end
        tx_en = 1'b0;
        rstn_async = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL sync_stage1_rx_ready: got %b want 0", rx_ready); end
        @(posedge clk);
        #1;
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL sync_release_rx_ready: got %b want 1", rx_ready); end
        $display("test_reset: reset values and synchronised release checked");
    endtask

    task automatic test_inc_basic();
        mode = 2'd0;
        tx_en = 1'b1;
        tx_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL inc_valid[%0d]: got %b want 1", i, tx_valid); end
            checks++; if (tx_data !== 64'(i) || tx_data !== ref_tx_word()) begin errors++; $display("FAIL inc_data[%0d]: got %h want %h", i, tx_data, 64'(i)); end
            $display("tx beat %0d data %h", i, tx_data);
            tick();
        end
        checks++; if (tx_count !== 32'd4) begin errors++; $display("FAIL inc_count4: got %0d want 4", tx_count); end
        tick();
        tx_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (tx_data !== 64'd5) begin errors++; $display("FAIL stall_data[%0d]: got %h want 5", i, tx_data); end
            checks++; if (tx_count !== 32'd5) begin errors++; $display("FAIL stall_count[%0d]: got %0d want 5", i, tx_count); end
            tick();
        end
        tx_ready = 1'b1;
        #1;
        tick();
        checks++; if (tx_data !== 64'd6) begin errors++; $display("FAIL resume_data: got %h want 6", tx_data); end
        checks++; if (tx_count !== 32'd6) begin errors++; $display("FAIL resume_count: got %0d want 6", tx_count); end
        // Withdraw valid in the middle of a stall: the pending word must survive.
        tx_ready = 1'b0;
        tick();
        tx_en = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL withdraw_valid: got %b want 0", tx_valid); end
        tick();
        tick();
        tx_en = 1'b1;
        tx_ready = 1'b1;
        #1;
        checks++; if (tx_data !== 64'd6) begin errors++; $display("FAIL withdraw_data: got %h want 6", tx_data); end
        tick();
        checks++; if (tx_data !== 64'd7 || tx_count !== 32'd7) begin errors++; $display("FAIL withdraw_resume: got %h/%0d want 7/7", tx_data, tx_count); end
        tx_en = 1'b0;
        $display("test_inc_basic: count %0d data %h", tx_count, tx_data);
    endtask

    task automatic test_inc_checker();
        logic [7:0] vals [4];
        int led_cycles;
        vals[0] = 8'h10; vals[1] = 8'h11; vals[2] = 8'h13; vals[3] = 8'h14;
        mode = 2'd0;
        do_clear();
        led_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            rx_valid_drv = 1'b1;
            rx_data_drv = vals[i];
            tick();
            if (err_led === 1'b1) led_cycles++;
            $display("rx beat %0d data %h err_count %0d", i, vals[i], err_count);
        end
        rx_valid_drv = 1'b0;
        checks++; if (err_count !== 32'd1) begin errors++; $display("FAIL inc_chk_errs: got %0d want 1", err_count); end
        checks++; if (rx_count !== 32'd4) begin errors++; $display("FAIL inc_chk_rxc: got %0d want 4", rx_count); end
        checks++; if (first_err_exp !== 8'h12 || first_err_got !== 8'h13) begin errors++; $display("FAIL inc_chk_first: got %h/%h want 12/13", first_err_exp, first_err_got); end
        checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL inc_chk_seen: got %b want 1", err_seen); end
        for (int i = 0; i < 30 && err_led === 1'b1; i++) begin
            tick();
            if (err_led === 1'b1) led_cycles++;
        end
        checks++; if (led_cycles != LED_HOLD) begin errors++; $display("FAIL led_hold: got %0d cycles want %0d", led_cycles, LED_HOLD); end
        checks++; if (err_led !== 1'b0 || err_seen !== 1'b1) begin errors++; $display("FAIL led_off: got led %b seen %b want 0/1", err_led, err_seen); end
        $display("test_inc_checker: led held %0d cycles", led_cycles);
    endtask

    task automatic test_lfsr_loop();
        int cyc;
        int bad_words;
        mode = 2'd1;
        do_clear();
        loop_en = 1'b1;
        cyc = 0;
        bad_words = 0;
        while (m_txc < 32'd1000 && cyc < 5000) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            tx_en = ($urandom_range(0, 7) != 0);
            #1;
            checks++;
            if (tx_data !== ref_tx_word() || tx_valid !== tx_en) begin
                errors++;
                bad_words++;
                if (bad_words <= 5) $display("FAIL lfsr_word[%0d]: got %h v%b want %h v%b", m_txc, tx_data, tx_valid, ref_tx_word(), tx_en);
            end
            tick();
            cyc++;
        end
        checks++; if (m_txc != 32'd1000) begin errors++; $display("FAIL lfsr_timeout: got %0d beats want 1000", m_txc); end
        checks++; if (tx_count !== 32'd1000 || rx_count !== 32'd1000) begin errors++; $display("FAIL lfsr_counts: got %0d/%0d want 1000/1000", tx_count, rx_count); end
        checks++; if (err_count !== 32'd0 || err_seen !== 1'b0) begin errors++; $display("FAIL lfsr_errs: got %0d seen %b want 0/0", err_count, err_seen); end
        tx_en = 1'b0;
        loop_en = 1'b0;
        $display("test_lfsr_loop: %0d beats in %0d cycles", tx_count, cyc);
    endtask

    task automatic test_rx_random(input logic [1:0] md);
        mode = md;
        do_clear();
        for (int i = 0; i < 300; i++) begin
            rx_valid_drv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 80) rx_data_drv = ref_rx_exp();
            else                            rx_data_drv = 8'($urandom);
            #1;
            tick();
            checks++;
            if (err_count !== m_errc || err_led !== (m_led_left > 0)) begin
                errors++;
                $display("FAIL rand_m%0d[%0d]: got errs %0d led %b want %0d %b", md, i, err_count, err_led, m_errc, (m_led_left > 0));
            end
        end
        rx_valid_drv = 1'b0;
        checks++; if (rx_count !== m_rxc) begin errors++; $display("FAIL rand_m%0d_rxc: got %0d want %0d", md, rx_count, m_rxc); end
        checks++; if (err_seen !== m_seen || first_err_exp !== m_fexp || first_err_got !== m_fgot) begin errors++; $display("FAIL rand_m%0d_first: got %b %h %h want %b %h %h", md, err_seen, first_err_exp, first_err_got, m_seen, m_fexp, m_fgot); end
        $display("test_rx_random mode %0d: rx %0d errs %0d", md, rx_count, err_count);
    endtask

    task automatic test_clear_priority();
        mode = 2'd0;
        tx_en = 1'b1;
        tx_ready = 1'b1;
        rx_valid_drv = 1'b1;
        rx_data_drv = 8'h00;
        clear = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL clear_tx_valid: got %b want 0", tx_valid); end
        tick();
        clear = 1'b0;
        tx_en = 1'b0;
        rx_valid_drv = 1'b0;
        #1;
        checks++; if ({tx_count, rx_count, err_count} !== 96'd0) begin errors++; $display("FAIL clear_counts: got %0d/%0d/%0d want 0", tx_count, rx_count, err_count); end
        checks++; if ({err_seen, err_led, first_err_exp, first_err_got} !== 18'd0 || tx_data !== 64'd0) begin errors++; $display("FAIL clear_state: got %b %b %h %h data %h want 0", err_seen, err_led, first_err_exp, first_err_got, tx_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL clear_rx_ready: got %b want 1", rx_ready); end
        rx_valid_drv = 1'b1;
        rx_data_drv = 8'h55;
        tick();
        rx_data_drv = 8'h56;
        tick();
        rx_valid_drv = 1'b0;
        checks++; if (err_count !== 32'd0 || rx_count !== 32'd2) begin errors++; $display("FAIL clear_relock: got errs %0d rx %0d want 0/2", err_count, rx_count); end
        $display("test_clear_priority: relocked at 55");
    endtask

    task automatic test_saturation();
        mode = 2'd2;
        do_clear();
        force dut.u_err_cnt.count_reg = 32'hFFFF_FFFC;
        #1;
        release dut.u_err_cnt.count_reg;
        m_errc = 32'hFFFF_FFFC;
        for (int i = 0; i < 6; i++) begin
            rx_valid_drv = 1'b1;
            rx_data_drv = 8'h00;
            tick();
            checks++; if (err_count !== m_errc) begin errors++; $display("FAIL sat_step[%0d]: got %h want %h", i, err_count, m_errc); end
        end
        rx_valid_drv = 1'b0;
        checks++; if (err_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %h want ffffffff", err_count); end
        $display("test_saturation: err_count %h", err_count);
    endtask

    task automatic test_async_reset();
        mode = 2'd0;
        do_clear();
        tx_en = 1'b1;
        tx_ready = 1'b1;
        repeat (5) tick();
        #3;
        rstn_async = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin errors++; $display("FAIL arst_handshake: got v%b r%b want 0/0", tx_valid, rx_ready); end
        checks++; if (tx_count !== 32'd0 || tx_data !== 64'd0) begin errors++; $display("FAIL arst_state: got %0d %h want 0/0", tx_count, tx_data); end
        tx_en = 1'b0;
        @(posedge clk);
        #1;
        rstn_async = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_ready !== 1'b1 || tx_count !== 32'd0) begin errors++; $display("FAIL arst_release: got r%b cnt %0d want 1/0", rx_ready, tx_count); end
        $display("test_async_reset: recovered");
    endtask

    initial begin
        mode = 2'd0;
        tx_en = 1'b0;
        clear = 1'b0;
        tx_ready = 1'b0;
        loop_en = 1'b0;
        rx_valid_drv = 1'b0;
        rx_data_drv = 8'h00;
        model_reset();
        test_reset();
        test_inc_basic();
        test_inc_checker();
        test_lfsr_loop();
        test_rx_random(2'd0);
        test_rx_random(2'd1);
        test_rx_random(2'd2);
        test_rx_random(2'd3);
        test_clear_priority();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
